// File: rtl/game_sequencer_if.sv
// Play-field link between the Breakout sequencer and the ball/bar/blocks modules.
// The sequencer (master) steers the ball and reload; the play field (slave) reports events.
interface game_sequencer_if;
  logic        block_hit;
  logic        ball_lost;
  logic [32:0] Blocks;
  logic        ball_hold;
  logic        ball_run;
  logic        level_load;

  modport master (
    input  block_hit, ball_lost, Blocks,
    output ball_hold, ball_run, level_load
  );

  modport slave (
    output block_hit, ball_lost, Blocks,
    input  ball_hold, ball_run, level_load
  );
endinterface

// File: rtl/game_sequencer.sv
// Breakout game controller: phase FSM plus lives, level and BCD score bookkeeping.
// Frame timing comes from VGA_VS, resynchronised into the Clk domain.
module game_sequencer #(
  parameter int unsigned LIVES_INIT   = 3,
  parameter int unsigned PAUSE_FRAMES = 60,
  parameter int unsigned POINTS       = 1,
  parameter logic [7:0]  KEY_START    = 8'h28,
  parameter logic [7:0]  KEY_LAUNCH   = 8'h2C
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                frame_clk,
  input  logic [7:0]          keycode,
  game_sequencer_if.master    play,
  output logic [1:0]          lives,
  output logic [3:0]          level,
  output logic [15:0]         score_bcd,
  output logic [2:0]          state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    PLAY  = 3'd2,
    MISS  = 3'd3,
    CLEAR = 3'd4,
    OVER  = 3'd5
  } state_t;

  localparam int             CNT_W     = (PAUSE_FRAMES < 2) ? 1 : $clog2(PAUSE_FRAMES + 1);
  localparam logic [CNT_W:0] PAUSE_LIM = PAUSE_FRAMES[CNT_W:0];
  localparam logic [1:0]     LIVES_RST = LIVES_INIT[1:0];
  localparam logic [3:0]     PTS       = POINTS[3:0];

  state_t           state_q, state_d;
  logic             frame_meta, frame_sync, frame_prev, frame_tick;
  logic [7:0]       key_prev;
  logic             start_press, launch_press;
  logic [CNT_W-1:0] pause_cnt;
  logic [CNT_W:0]   pause_cnt_next;
  logic             pause_done;
  logic             load_d, start_game, score_en, miss_en, level_inc;
  logic [1:0]       lives_q;
  logic [3:0]       level_q;
  logic [15:0]      score_q;
  logic [16:0]      score_sum;
  logic [15:0]      score_next;
  logic             hold_q, run_q, load_q;

  // Adds pts to a 4-digit BCD value; bit 16 flags a carry out of the top digit.
  function automatic logic [16:0] bcd_add(input logic [15:0] a, input logic [3:0] pts);
    logic [15:0] sum;
    logic        carry;
    logic [4:0]  d;
    sum   = '0;
    carry = 1'b0;
    for (int i = 0; i < 4; i++) begin
      d = {1'b0, a[i*4 +: 4]} + {1'b0, (i == 0) ? pts : 4'd0} + {4'd0, carry};
      if (d > 5'd9) begin
        sum[i*4 +: 4] = 4'(d - 5'd10);
        carry         = 1'b1;
      end else begin
        sum[i*4 +: 4] = d[3:0];
        carry         = 1'b0;
      end
    end
    return {carry, sum};
  endfunction

  // Two flops tame the asynchronous VGA_VS; the third gives the edge detector its history.
  always_ff @(posedge Clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (Reset) begin
      frame_meta <= 1'b0;
      frame_sync <= 1'b0;
      frame_prev <= 1'b0;
      frame_tick <= 1'b0;
      key_prev   <= 8'd0;
    end else begin
      frame_meta <= frame_clk;
      frame_sync <= frame_meta;
      frame_prev <= frame_sync;
      frame_tick <= frame_sync & ~frame_prev;
      key_prev   <= keycode;
    end
  end

  assign start_press  = (keycode == KEY_START)  && (key_prev != KEY_START);
  assign launch_press = (keycode == KEY_LAUNCH) && (key_prev != KEY_LAUNCH);

  // The pause ends on the PAUSE_FRAMES-th tick, or on the first tick when PAUSE_FRAMES is 0.
  assign pause_cnt_next = {1'b0, pause_cnt} + 1'b1;
  assign pause_done     = frame_tick && (pause_cnt_next >= PAUSE_LIM);

  always_ff @(posedge Clk) begin
    if (Reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d    = state_q;
    load_d     = 1'b0;
    start_game = 1'b0;
    score_en   = 1'b0;
    miss_en    = 1'b0;
    level_inc  = 1'b0;
    case (state_q)
      IDLE, OVER: begin
        if (start_press) begin
          state_d    = SERVE;
          load_d     = 1'b1;
          start_game = 1'b1;
        end
      end
      SERVE: begin
        if (launch_press) state_d = PLAY;
      end
      PLAY: begin
        score_en = play.block_hit;
        // A cleared field wins over a lost ball in the same cycle.
        if (play.Blocks == '0) begin
          state_d = CLEAR;
        end else if (play.ball_lost) begin
          state_d = MISS;
          miss_en = 1'b1;
        end
      end
      MISS: begin
        if (pause_done) state_d = (lives_q == 2'd0) ? OVER : SERVE;
      end
      CLEAR: begin
        if (pause_done) begin
          state_d   = SERVE;
          load_d    = 1'b1;
          level_inc = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      pause_cnt <= '0;
    end else if (state_d != state_q) begin
      pause_cnt <= '0;
    end else if ((state_q == MISS || state_q == CLEAR) && frame_tick) begin
      pause_cnt <= pause_cnt_next[CNT_W-1:0];
    end
  end

  assign score_sum  = bcd_add(score_q, PTS);
  assign score_next = score_sum[16] ? 16'h9999 : score_sum[15:0];

  always_ff @(posedge Clk) begin
    if (Reset) begin
      lives_q <= LIVES_RST;
      level_q <= 4'd1;
      score_q <= 16'h0000;
      hold_q  <= 1'b0;
      run_q   <= 1'b0;
      load_q  <= 1'b0;
    end else begin
      load_q <= load_d;
      hold_q <= (state_q == SERVE);
      run_q  <= (state_q == PLAY);
      if (start_game) begin
        lives_q <= LIVES_RST;
        level_q <= 4'd1;
        score_q <= 16'h0000;
      end else begin
        if (score_en)                        score_q <= score_next;
        if (miss_en && lives_q != 2'd0)      lives_q <= lives_q - 2'd1;
        if (level_inc && level_q != 4'd15)   level_q <= level_q + 4'd1;
      end
    end
  end

  assign play.ball_hold  = hold_q;
  assign play.ball_run   = run_q;
  assign play.level_load = load_q;
  assign lives           = lives_q;
  assign level           = level_q;
  assign score_bcd       = score_q;
  assign state           = state_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Self-checking bench for game_sequencer: scenario tasks with a score/lives/level model
// kept as plain integers and converted to BCD only for comparison.
module tb_game_sequencer;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        frame_clk = 1'b0;
  logic [7:0]  keycode = 8'd0;
  logic [1:0]  lives;
  logic [3:0]  level;
  logic [15:0] score_bcd;
  logic [2:0]  state;

  game_sequencer_if pif ();

  game_sequencer dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .frame_clk (frame_clk),
    .keycode   (keycode),
    .play      (pif),
    .lives     (lives),
    .level     (level),
    .score_bcd (score_bcd),
    .state     (state)
  );

  always #5 Clk = ~Clk;

  int n_cmp = 0;
  int n_bad = 0;
  int m_score = 0;
  int load_cnt = 0;
  int tick_cnt = 0;

  always @(negedge Clk) begin
    if (pif.level_load === 1'b1) load_cnt++;
    if (dut.frame_tick === 1'b1) tick_cnt++;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic logic [15:0] to_bcd(input int v);
    int c;
    c = (v > 9999) ? 9999 : v;
    return {4'((c / 1000) % 10), 4'((c / 100) % 10), 4'((c / 10) % 10), 4'(c % 10)};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      frame_clk = 1'b1;
      tick(int'($urandom_range(4, 7)));
      frame_clk = 1'b0;
      tick(int'($urandom_range(4, 7)));
    end
  endtask

  task automatic press(input logic [7:0] k);
    keycode = k;
    tick(1);
    keycode = 8'd0;
    tick(3);
  endtask

  task automatic lose_ball();
    pif.ball_lost = 1'b1;
    tick(1);
    pif.ball_lost = 1'b0;
    tick(2);
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    tick(3);
    Reset = 1'b0;
    tick(1);
    n_cmp++; if (state !== 3'd0) begin n_bad++; $display("FAIL reset_state: got %0d want 0", state); end
    n_cmp++; if (lives !== 2'd3) begin n_bad++; $display("FAIL reset_lives: got %0d want 3", lives); end
    n_cmp++; if (level !== 4'd1) begin n_bad++; $display("FAIL reset_level: got %0d want 1", level); end
    n_cmp++; if (score_bcd !== 16'h0000) begin n_bad++; $display("FAIL reset_score: got %h want 0000", score_bcd); end
    n_cmp++; if ({pif.ball_hold, pif.ball_run, pif.level_load} !== 3'b000) begin
      n_bad++; $display("FAIL reset_outputs: got %b want 000", {pif.ball_hold, pif.ball_run, pif.level_load});
    end
  endtask

  task automatic test_start();
    int l0;
    l0 = load_cnt;
    keycode = 8'h28;
    tick(10);
    keycode = 8'd0;
    tick(2);
    n_cmp++; if (load_cnt - l0 != 1) begin n_bad++; $display("FAIL start_load_pulses: got %0d want 1", load_cnt - l0); end
    n_cmp++; if (state !== 3'd1) begin n_bad++; $display("FAIL start_state: got %0d want 1", state); end
    n_cmp++; if (pif.ball_hold !== 1'b1) begin n_bad++; $display("FAIL start_hold: got %b want 1", pif.ball_hold); end
    n_cmp++; if (lives !== 2'd3) begin n_bad++; $display("FAIL start_lives: got %0d want 3", lives); end
    n_cmp++; if (score_bcd !== 16'h0000) begin n_bad++; $display("FAIL start_score: got %h want 0000", score_bcd); end
    m_score = 0;
  endtask

  task automatic test_serve_ignore();
    pif.block_hit = 1'b1;
    pif.ball_lost = 1'b1;
    tick(1);
    pif.block_hit = 1'b0;
    pif.ball_lost = 1'b0;
    tick(2);
    n_cmp++; if (state !== 3'd1) begin n_bad++; $display("FAIL serve_ignore_state: got %0d want 1", state); end
    n_cmp++; if (score_bcd !== to_bcd(m_score)) begin n_bad++; $display("FAIL serve_ignore_score: got %h want %h", score_bcd, to_bcd(m_score)); end
    n_cmp++; if (lives !== 2'd3) begin n_bad++; $display("FAIL serve_ignore_lives: got %0d want 3", lives); end
  endtask

  task automatic test_launch_score();
    press(8'h2C);
    n_cmp++; if (state !== 3'd2) begin n_bad++; $display("FAIL launch_state: got %0d want 2", state); end
    n_cmp++; if ({pif.ball_hold, pif.ball_run} !== 2'b01) begin
      n_bad++; $display("FAIL launch_ball: got hold/run %b want 01", {pif.ball_hold, pif.ball_run});
    end
    for (int i = 0; i < 12; i++) begin
      pif.block_hit = 1'b1;
      tick(1);
      pif.block_hit = 1'b0;
      m_score += 1;
      tick(int'($urandom_range(0, 3)));
    end
    n_cmp++; if (score_bcd !== 16'h0012) begin n_bad++; $display("FAIL score_12_hits: got %h want 0012", score_bcd); end
  endtask

  task automatic test_miss();
    lose_ball();
    n_cmp++; if (state !== 3'd3) begin n_bad++; $display("FAIL miss_state: got %0d want 3", state); end
    n_cmp++; if (lives !== 2'd2) begin n_bad++; $display("FAIL miss_lives: got %0d want 2", lives); end
    n_cmp++; if ({pif.ball_hold, pif.ball_run} !== 2'b00) begin
      n_bad++; $display("FAIL miss_ball: got hold/run %b want 00", {pif.ball_hold, pif.ball_run});
    end
    frames(59);
    n_cmp++; if (state !== 3'd3) begin n_bad++; $display("FAIL miss_59_frames: got %0d want 3", state); end
    frames(1);
    tick(2);
    n_cmp++; if (state !== 3'd1) begin n_bad++; $display("FAIL miss_60_frames: got %0d want 1", state); end
    n_cmp++; if (lives !== 2'd2) begin n_bad++; $display("FAIL miss_lives_kept: got %0d want 2", lives); end
  endtask

  task automatic test_game_over();
    press(8'h2C);
    lose_ball();
    n_cmp++; if (lives !== 2'd1) begin n_bad++; $display("FAIL over_lives1: got %0d want 1", lives); end
    frames(60);
    tick(2);
    press(8'h2C);
    lose_ball();
    n_cmp++; if (lives !== 2'd0) begin n_bad++; $display("FAIL over_lives0: got %0d want 0", lives); end
    frames(60);
    tick(2);
    n_cmp++; if (state !== 3'd5) begin n_bad++; $display("FAIL over_state: got %0d want 5", state); end
    n_cmp++; if ({pif.ball_hold, pif.ball_run} !== 2'b00) begin
      n_bad++; $display("FAIL over_ball: got hold/run %b want 00", {pif.ball_hold, pif.ball_run});
    end
    pif.block_hit = 1'b1;
    tick(1);
    pif.block_hit = 1'b0;
    tick(2);
    n_cmp++; if (score_bcd !== to_bcd(m_score)) begin n_bad++; $display("FAIL over_score_held: got %h want %h", score_bcd, to_bcd(m_score)); end
  endtask

  task automatic test_restart();
    int l0;
    l0 = load_cnt;
    press(8'h28);
    m_score = 0;
    n_cmp++; if (load_cnt - l0 != 1) begin n_bad++; $display("FAIL restart_load: got %0d want 1", load_cnt - l0); end
    n_cmp++; if (state !== 3'd1) begin n_bad++; $display("FAIL restart_state: got %0d want 1", state); end
    n_cmp++; if (score_bcd !== 16'h0000) begin n_bad++; $display("FAIL restart_score: got %h want 0000", score_bcd); end
    n_cmp++; if (lives !== 2'd3) begin n_bad++; $display("FAIL restart_lives: got %0d want 3", lives); end
    n_cmp++; if (level !== 4'd1) begin n_bad++; $display("FAIL restart_level: got %0d want 1", level); end
  endtask

  task automatic test_clear();
    int l0;
    press(8'h2C);
    pif.Blocks    = '0;
    pif.block_hit = 1'b1;
    pif.ball_lost = 1'b1;
    tick(1);
    pif.block_hit = 1'b0;
    pif.ball_lost = 1'b0;
    pif.Blocks    = '1;
    m_score += 1;
    tick(2);
    n_cmp++; if (state !== 3'd4) begin n_bad++; $display("FAIL clear_state: got %0d want 4", state); end
    n_cmp++; if (lives !== 2'd3) begin n_bad++; $display("FAIL clear_lives: got %0d want 3", lives); end
    n_cmp++; if (score_bcd !== to_bcd(m_score)) begin n_bad++; $display("FAIL clear_score: got %h want %h", score_bcd, to_bcd(m_score)); end
    l0 = load_cnt;
    frames(60);
    tick(2);
    n_cmp++; if (load_cnt - l0 != 1) begin n_bad++; $display("FAIL clear_load: got %0d want 1", load_cnt - l0); end
    n_cmp++; if (level !== 4'd2) begin n_bad++; $display("FAIL clear_level: got %0d want 2", level); end
    n_cmp++; if (state !== 3'd1) begin n_bad++; $display("FAIL clear_exit_state: got %0d want 1", state); end
  endtask

  task automatic test_reset_mid_miss();
    press(8'h2C);
    lose_ball();
    frames(30);
    n_cmp++; if (int'(dut.pause_cnt) != 30) begin n_bad++; $display("FAIL midmiss_count: got %0d want 30", dut.pause_cnt); end
    Reset = 1'b1;
    tick(1);
    n_cmp++; if (state !== 3'd0) begin n_bad++; $display("FAIL midmiss_state: got %0d want 0", state); end
    n_cmp++; if (lives !== 2'd3) begin n_bad++; $display("FAIL midmiss_lives: got %0d want 3", lives); end
    n_cmp++; if (score_bcd !== 16'h0000) begin n_bad++; $display("FAIL midmiss_score: got %h want 0000", score_bcd); end
    n_cmp++; if (level !== 4'd1) begin n_bad++; $display("FAIL midmiss_level: got %0d want 1", level); end
    n_cmp++; if (int'(dut.pause_cnt) != 0) begin n_bad++; $display("FAIL midmiss_counter: got %0d want 0", dut.pause_cnt); end
    n_cmp++; if ({pif.ball_hold, pif.ball_run, pif.level_load} !== 3'b000) begin
      n_bad++; $display("FAIL midmiss_outputs: got %b want 000", {pif.ball_hold, pif.ball_run, pif.level_load});
    end
    Reset = 1'b0;
    m_score = 0;
    tick(1);
  endtask

  task automatic test_random_play();
    press(8'h28);
    press(8'h2C);
    m_score = 0;
    for (int i = 0; i < 300; i++) begin
      pif.block_hit = ($urandom_range(0, 2) == 0);
      keycode       = 8'($urandom_range(0, 255));
      if (pif.block_hit) m_score += 1;
      tick(1);
      if (i % 60 == 59) begin
        n_cmp++; if (score_bcd !== to_bcd(m_score)) begin n_bad++; $display("FAIL random_score: got %h want %h", score_bcd, to_bcd(m_score)); end
      end
    end
    pif.block_hit = 1'b0;
    keycode       = 8'd0;
    tick(2);
    n_cmp++; if (state !== 3'd2) begin n_bad++; $display("FAIL random_state: got %0d want 2", state); end
    n_cmp++; if (lives !== 2'd3) begin n_bad++; $display("FAIL random_lives: got %0d want 3", lives); end
  endtask

  task automatic test_saturate();
    pif.block_hit = 1'b1;
    tick(9998 - m_score);
    n_cmp++; if (score_bcd !== 16'h9998) begin n_bad++; $display("FAIL sat_9998: got %h want 9998", score_bcd); end
    tick(1);
    n_cmp++; if (score_bcd !== 16'h9999) begin n_bad++; $display("FAIL sat_9999: got %h want 9999", score_bcd); end
    tick(1);
    pif.block_hit = 1'b0;
    tick(1);
    n_cmp++; if (score_bcd !== 16'h9999) begin n_bad++; $display("FAIL sat_hold: got %h want 9999", score_bcd); end
  endtask

  task automatic test_frame_tick();
    int t0;
    int rises;
    rises = 20 + int'($urandom_range(0, 10));
    t0 = tick_cnt;
    for (int i = 0; i < rises; i++) begin
      frame_clk = 1'b1;
      tick(5);
      frame_clk = 1'b0;
      tick(5);
    end
    n_cmp++; if (tick_cnt - t0 != rises) begin n_bad++; $display("FAIL frame_ticks: got %0d want %0d", tick_cnt - t0, rises); end
  endtask

  initial begin
    pif.block_hit = 1'b0;
    pif.ball_lost = 1'b0;
    pif.Blocks    = '1;
    test_reset();
    test_start();
    test_serve_ignore();
    test_launch_score();
    test_miss();
    test_game_over();
    test_restart();
    test_clear();
    test_reset_mid_miss();
    test_random_play();
    test_saturate();
    test_frame_tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/game_sequencer.md
Name: game_sequencer

Overview:
- Top-level Breakout game controller: sequences ball, bar and block logic through attract, serve, play, miss, level-clear and game-over phases.
- Sits beside the ball/bar/blocks modules, driven by the USB keycode and VGA vertical sync. Owns lives, level number and the 4-digit BCD score shown on the HEX displays.

Parameters:
- LIVES_INIT, 3, lives loaded at game start (1..3).
- PAUSE_FRAMES, 60, frame ticks spent in MISS and CLEAR before continuing.
- POINTS, 1, BCD points added per block hit (1..9).
- KEY_START, 8'h28, HID keycode (Enter) that starts or restarts a game.
- KEY_LAUNCH, 8'h2C, HID keycode (Space) that launches the ball from the bar.

Ports:
- Clk  input  1  system clock (50 MHz).
- Reset  input  1  synchronous, active-high reset.
- frame_clk  input  1  VGA_VS, asynchronous to Clk; rising edge = one frame.
- keycode  input  8  current USB keycode, 0 when no key is held.
- block_hit  input  1  one-Clk pulse per block destroyed.
- ball_lost  input  1  one-Clk pulse when the ball passes below the bar.
- Blocks  input  33  live-block bitmap; all-zero means the level is cleared.
- ball_hold  output  1  ball rides on the bar (SERVE).
- ball_run  output  1  ball motion enabled (PLAY).
- level_load  output  1  one-Clk pulse telling blocks to reload the bitmap.
- lives  output  2  remaining lives.
- level  output  4  current level number, starting at 1.
- score_bcd  output  16  four BCD digits, [15:12] most significant.
- state  output  3  encoded state, for debug and LEDs.

Behaviour:
- Frame tick:
  - frame_clk passes through a 2-FF synchronizer, then rising-edge detection.
  - frame_tick is a one-Clk pulse, 3 Clk cycles after the VGA_VS rise.
- Key press detection:
  - keycode is registered each cycle.
  - start_press = (keycode==KEY_START) && (prev!=KEY_START); launch_press is formed the same way with KEY_LAUNCH.
  - A held key fires exactly once.
- States and encodings: IDLE=0, SERVE=1, PLAY=2, MISS=3, CLEAR=4, OVER=5. Encodings 6 and 7 return to IDLE on the next cycle.
- Reset takes priority over everything, mid-operation included. It forces:
  - state=IDLE, lives=LIVES_INIT, level=1, score=0;
  - ball_hold=0, ball_run=0, level_load=0;
  - pause counter=0, key history=0.
- IDLE: on start_press, go to SERVE. In the same cycle: level_load=1, score=0, lives=LIVES_INIT, level=1.
- SERVE:
  - ball_hold=1.
  - launch_press goes to PLAY.
  - block_hit and ball_lost are ignored.
- PLAY: ball_run=1. In each cycle:
  - block_hit adds POINTS to the score in BCD with per-digit carry, saturating at 9999.
  - If Blocks==0, go to CLEAR.
  - Else if ball_lost, go to MISS and decrement lives (saturating at 0).
  - A simultaneous block_hit still scores in that cycle. Blocks==0 beats ball_lost; lives are not decremented in that case.
- MISS:
  - Ball outputs are 0.
  - The pause counter counts frame_ticks up to PAUSE_FRAMES. On reaching it, go to OVER if lives==0, else to SERVE.
  - The counter clears on every state entry.
- CLEAR:
  - Pauses for PAUSE_FRAMES frame_ticks, then goes to SERVE with level_load=1.
  - level increments, saturating at 15.
- OVER:
  - Ball outputs are 0; score and level are held for display.
  - start_press behaves as in IDLE: a full restart straight into SERVE.
- Output timing: all outputs are registered, so ball_hold and ball_run change in the cycle after the transition. level_load is high for exactly one Clk.
- PAUSE_FRAMES=0: MISS and CLEAR leave on the first frame_tick.

Test Plan:
- Reset, then keycode 0x28 held for 10 cycles: exactly one level_load pulse, state=1, ball_hold=1, lives=3, score=0000; holding 0x28 has no further effect.
- In SERVE, keycode 0x2C: state=2, ball_run=1; 12 block_hit pulses with POINTS=1 give score_bcd=16'h0012; from 9999, one more hit stays at 16'h9999.
- In PLAY, ball_lost: state=3, lives 3->2. After 60 frame_clk rises: state=1. With lives=1, the same sequence ends in state=5 with lives=0.
- In PLAY with Blocks going to 0 in the same cycle as ball_lost and block_hit: state=4, lives unchanged, score+1. After 60 frames: level_load pulse, level=2, state=1.
- Reset asserted mid-MISS with the pause counter at 30: next cycle state=0, lives=3, score=0, counter=0, all ball outputs 0.
- In OVER, keycode 0x28: state=1, score cleared, lives=3, level=1, one level_load pulse. A frame_clk glitch-free square wave gives exactly one frame_tick per rising edge.
